spr_bank: RTL and testbench

SPR_BANK -- requirements
Module: spr_bank

---
 rtl/spr_pkg.sv | 32 +++
 rtl/spr_save_stack.sv | 46 ++++
 rtl/spr_bank.sv | 129 ++++++++++++
 tb/tb_spr_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/spr_pkg.sv
// Shared definitions for the special-purpose register bank:
// register index map, MODE encoding and the saved-context record.
package spr_pkg;

    // Register index map
    localparam int SPR_SR    = 0;
    localparam int SPR_ESR   = 1;
    localparam int SPR_ECA   = 2;
    localparam int SPR_EPC   = 3;
    localparam int SPR_EDATA = 4;
    localparam int SPR_PTO   = 5;
    localparam int SPR_PTL   = 6;
    localparam int SPR_MODE  = 7;

    // MODE register encoding
    localparam logic MODE_SYS = 1'b0;
    localparam logic MODE_USR = 1'b1;

    // Widest register the saved-context record can carry; narrower banks
    // use the low DATA_W bits of each field and leave the rest zero.
    localparam int SPR_MAX_W = 64;

    // One nested interrupt context
    typedef struct packed {
        logic [SPR_MAX_W-1:0] esr;
        logic [SPR_MAX_W-1:0] eca;
        logic [SPR_MAX_W-1:0] epc;
        logic [SPR_MAX_W-1:0] edata;
        logic [SPR_MAX_W-1:0] mode;
    } spr_ctx_t;

endpackage

// File: rtl/spr_save_stack.sv
// LIFO of saved interrupt contexts. Push is ignored when full and pop is
// ignored when empty; push wins if both arrive together. top reads zero
// while the stack is empty.
module spr_save_stack
    import spr_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int DPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  spr_ctx_t       push_data,
    output spr_ctx_t       top,
    output logic [DPW-1:0] depth,
    output logic           full,
    output logic           empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    spr_ctx_t       r_mem [DEPTH];
    logic [DPW-1:0] r_depth;
    logic [IW-1:0]  w_top_idx;

    assign full      = (r_depth == DPW'(DEPTH));
    assign empty     = (r_depth == '0);
    assign depth     = r_depth;
    assign w_top_idx = IW'(r_depth - DPW'(1));
    assign top       = empty ? '0 : r_mem[w_top_idx];

    // Storage and occupancy; reset wipes every entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_depth <= '0;
        end else if (push && !full) begin
            r_mem[IW'(r_depth)] <= push_data;
            r_depth             <= r_depth + DPW'(1);
        end else if (pop && !empty) begin
            r_depth <= r_depth - DPW'(1);
        end
    end

endmodule

// File: rtl/spr_bank.sv
// Special-purpose register bank with interrupt entry/return handling.
// Define SPR_STACK_EN to add a nested-context save stack; without it
// eret only restores SR and forces user mode, and depth/ovf/unf read 0.
module spr_bank
    import spr_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int NUM_SPR     = 8,
    parameter  int MCA_W       = 23,
    parameter  int STACK_DEPTH = 4,
    localparam int SW          = $clog2(NUM_SPR),
    localparam int DPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jisr,
    input  logic              eret,
    input  logic [MCA_W-1:0]  mca,
    input  logic              rpt,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] next_pc,
    input  logic [DATA_W-1:0] ea,
    input  logic [SW-1:0]     sel,
    input  logic              sprw,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] spr_out,
    output logic [DATA_W-1:0] sr,
    output logic [DATA_W-1:0] mode,
    output logic [DPW-1:0]    depth,
    output logic              ovf,
    output logic              unf
);

    logic [DATA_W-1:0] r_spr [NUM_SPR];
    spr_ctx_t          w_top;
    logic              w_restore;   // eret pops a saved context
    logic              w_unused_top;

    assign spr_out = r_spr[sel];
    assign sr      = r_spr[SPR_SR];
    assign mode    = r_spr[SPR_MODE];

`ifdef SPR_STACK_EN
    spr_ctx_t       w_push_ctx;
    logic           w_push, w_pop, w_full, w_empty;
    logic [DPW-1:0] w_depth;
    logic           r_ovf, r_unf;

    // Snapshot of the context about to be overwritten by interrupt entry
    always_comb begin
        w_push_ctx = '0;
        w_push_ctx.esr[DATA_W-1:0]   = r_spr[SPR_ESR];
        w_push_ctx.eca[DATA_W-1:0]   = r_spr[SPR_ECA];
        w_push_ctx.epc[DATA_W-1:0]   = r_spr[SPR_EPC];
        w_push_ctx.edata[DATA_W-1:0] = r_spr[SPR_EDATA];
        w_push_ctx.mode[DATA_W-1:0]  = r_spr[SPR_MODE];
    end

    // jisr outranks eret, so a simultaneous pair never pops
    assign w_push    = jisr & ~w_full;
    assign w_pop     = eret & ~jisr & ~w_empty;
    assign w_restore = ~w_empty;

    spr_save_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_push_ctx),
        .top       (w_top),
        .depth     (w_depth),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Sticky overflow/underflow, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (jisr) begin
            if (w_full) r_ovf <= 1'b1;
        end else if (eret) begin
            if (w_empty) r_unf <= 1'b1;
        end
    end

    assign depth = w_depth;
    assign ovf   = r_ovf;
    assign unf   = r_unf;
`else
    assign w_top     = '0;
    assign w_restore = 1'b0;
    assign depth     = '0;
    assign ovf       = 1'b0;
    assign unf       = 1'b0;
`endif

    // Only the low DATA_W bits of each saved field are meaningful
    assign w_unused_top = ^{1'b0, w_top};

    // Register file update: jisr > eret > sprw
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPR; i++) r_spr[i] <= '0;
        end else if (jisr) begin
            r_spr[SPR_ESR]   <= r_spr[SPR_SR];
            r_spr[SPR_SR]    <= '0;
            r_spr[SPR_ECA]   <= DATA_W'(mca);
            r_spr[SPR_EPC]   <= rpt ? pc : next_pc;
            r_spr[SPR_EDATA] <= ea;
            r_spr[SPR_MODE]  <= DATA_W'(MODE_SYS);
        end else if (eret) begin
            r_spr[SPR_SR] <= r_spr[SPR_ESR];
            if (w_restore) begin
                r_spr[SPR_ESR]   <= w_top.esr[DATA_W-1:0];
                r_spr[SPR_ECA]   <= w_top.eca[DATA_W-1:0];
                r_spr[SPR_EPC]   <= w_top.epc[DATA_W-1:0];
                r_spr[SPR_EDATA] <= w_top.edata[DATA_W-1:0];
                r_spr[SPR_MODE]  <= w_top.mode[DATA_W-1:0];
            end else begin
                r_spr[SPR_MODE]  <= DATA_W'(MODE_USR);
            end
        end else if (sprw) begin
            r_spr[sel] <= data_in;
        end
    end

endmodule

// File: tb/tb_spr_bank.sv
// Bench for spr_bank: directed interrupt scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_spr_bank;

`ifdef SPR_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic        clk, rst_n, jisr, eret, rpt, sprw;
    logic [22:0] mca;
    logic [31:0] pc, next_pc, ea, data_in;
    logic [2:0]  sel;
    logic [31:0] spr_out, sr, mode;
    logic [2:0]  depth;
    logic        ovf, unf;

    spr_bank dut (
        .clk(clk), .rst_n(rst_n), .jisr(jisr), .eret(eret), .mca(mca),
        .rpt(rpt), .pc(pc), .next_pc(next_pc), .ea(ea), .sel(sel),
        .sprw(sprw), .data_in(data_in), .spr_out(spr_out), .sr(sr),
        .mode(mode), .depth(depth), .ovf(ovf), .unf(unf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model
    typedef struct {
        logic [31:0] esr, eca, epc, edata, mode;
    } ctx_t;

    logic [31:0] m_spr [8];
    ctx_t        m_stk [$];
    bit          m_ovf, m_unf;
    int          n_chk, n_fail;

    function automatic void model_step();
        ctx_t c;
        if (!rst_n) begin
            foreach (m_spr[i]) m_spr[i] = '0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (jisr) begin
            if (STK_EN) begin
                if (m_stk.size() < 4)
                    m_stk.push_back('{m_spr[1], m_spr[2], m_spr[3], m_spr[4], m_spr[7]});
                else
                    m_ovf = 1'b1;
            end
            m_spr[1] = m_spr[0];
            m_spr[0] = '0;
            m_spr[2] = {9'd0, mca};
            m_spr[3] = rpt ? pc : next_pc;
            m_spr[4] = ea;
            m_spr[7] = 32'd0;
        end else if (eret) begin
            m_spr[0] = m_spr[1];
            if (STK_EN && m_stk.size() > 0) begin
                c = m_stk.pop_back();
                m_spr[1] = c.esr;
                m_spr[2] = c.eca;
                m_spr[3] = c.epc;
                m_spr[4] = c.edata;
                m_spr[7] = c.mode;
            end else begin
                m_spr[7] = 32'd1;
                if (STK_EN) m_unf = 1'b1;
            end
        end else if (sprw) begin
            m_spr[sel] = data_in;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes, then a full sweep of the bank
    task automatic step(input bit rn, input bit j, input bit e, input bit w);
        rst_n = rn; jisr = j; eret = e; sprw = w;
        @(posedge clk);
        model_step();
        #1;
        rst_n = 1'b1; jisr = 1'b0; eret = 1'b0; sprw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            check($sformatf("spr%0d", i), spr_out, m_spr[i]);
        end
        check("sr", sr, m_spr[0]);
        check("mode", mode, m_spr[7]);
        check("depth", 32'(depth), 32'(m_stk.size()));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("unf", 32'(unf), 32'(m_unf));
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; jisr = 1'b0; eret = 1'b0; sprw = 1'b0; rpt = 1'b0;
        mca = '0; pc = '0; next_pc = '0; ea = '0; sel = '0; data_in = '0;
        foreach (m_spr[i]) m_spr[i] = 32'hx;
        m_ovf = 1'b0; m_unf = 1'b0;

        // Reset, with strobes asserted that must be ignored
        data_in = 32'h1234_5678; sel = 3'd5;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 0, 0);

        // Plain write to SR
        sel = 3'd0; data_in = 32'h0000_00FF;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("req34_sr", sr, 32'hFF);

        // User mode, then interrupt entry
        sel = 3'd7; data_in = 32'd1;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        mca = 23'h4; rpt = 1'b0; pc = 32'h100; next_pc = 32'h104; ea = 32'h2000;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("req35_sr", sr, 32'd0);
        check("req35_mode", mode, 32'd0);
        check("req35_depth", 32'(depth), STK_EN ? 32'd1 : 32'd0);

        // Nested entry with repeat, then two returns
        rpt = 1'b1; pc = 32'h300; next_pc = 32'h304; mca = 23'h11; ea = 32'h4000;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("req36_depth1", 32'(depth), STK_EN ? 32'd1 : 32'd0);
        check("req36_mode1", mode, STK_EN ? 32'd0 : 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("req36_sr2", sr, STK_EN ? 32'hFF : 32'd0);
        check("req36_mode2", mode, 32'd1);

        // Five back-to-back entries overflow a four-deep stack
        rpt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_pc = 32'h1000 + 32'(k) * 4; mca = 23'(k + 1); ea = 32'h8000 + 32'(k);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("req37_depth", 32'(depth), STK_EN ? 32'd4 : 32'd0);
        check("req37_ovf", 32'(ovf), 32'(STK_EN));

        // Drain, then underflow
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("req38_mode", mode, 32'd1);
        check("req38_unf", 32'(unf), 32'(STK_EN));

        // All three strobes together: entry only
        sel = 3'd2; data_in = 32'h0000_DEAD; next_pc = 32'h500; mca = 23'h7;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("req38_combo_depth", 32'(depth), STK_EN ? 32'd1 : 32'd0);
        check("req38_combo_mode", mode, 32'd0);

        // Reset in the middle of nesting discards saved contexts
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("midrst_depth", 32'(depth), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            mca     = 23'($urandom);
            rpt     = 1'($urandom);
            pc      = $urandom;
            next_pc = $urandom;
            ea      = $urandom;
            sel     = 3'($urandom);
            data_in = $urandom;
            step(($urandom_range(0, 99) >= 3),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
